fc_feeder: RTL and testbench

Activation sequencer on the producer side of the fully-connected MAC in the BNN-VAD datapath. It collects one frame of 108 two-bit binarized activations, arriving serially from the preceding layer, and stores them in three 36-entry banks. It then streams the frame to the MAC as 36 beats of three lanes, in the reverse-index order the MAC's weight indexing expects. It waits for the MAC's completion before accepting the next frame.

---
 rtl/fc_pkg.sv | 16 +
 rtl/fc_bank.sv | 28 ++
 rtl/fc_feeder.sv | 197 +++++++++++++++++++
 tb/tb_fc_feeder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared constants and state type for the fully-connected layer activation feeder.
package fc_pkg;

    localparam int FC_BEATS = 36;
    localparam int FC_LANES = 3;
    localparam int FC_FRAME = 108;
    localparam int FC_AW    = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        STREAM    = 2'd2,
        WAIT_DONE = 2'd3
    } fc_feed_state_t;

endpackage

// File: rtl/fc_bank.sv
// One activation bank: a small register file with one write port and a combinational read port.
module fc_bank
    import fc_pkg::*;
#(
    parameter int DEPTH = FC_BEATS,
    parameter int W     = FC_AW,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    // Contents are deliberately not reset: every entry is rewritten before it is read.
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fc_feeder.sv
// Collects one frame of binarized activations into three banks and streams it to the MAC
// in reverse-index order, then waits for the MAC to finish before taking the next frame.
module fc_feeder
    import fc_pkg::*;
#(
    parameter int BEATS   = FC_BEATS,
    parameter int N_LANE  = FC_LANES,
    parameter int TIMEOUT = 63
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             feat_valid_i,
    output logic             feat_ready_o,
    input  logic [FC_AW-1:0] feat_data_i,
    output logic [FC_AW-1:0] mac_in1_o,
    output logic [FC_AW-1:0] mac_in2_o,
    output logic [FC_AW-1:0] mac_in3_o,
    output logic             mac_valid_o,
    output logic             mac_start_o,
    input  logic             mac_done_i,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             err_timeout_o
);

    localparam int FRAME  = BEATS * N_LANE;
    localparam int ADDR_W = $clog2(BEATS);
    localparam int IDX_W  = $clog2(FRAME);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(FRAME - 1);
    localparam logic [IDX_W-1:0]  BANK1_BASE = IDX_W'(BEATS);
    localparam logic [IDX_W-1:0]  BANK2_BASE = IDX_W'(2 * BEATS);
    localparam logic [ADDR_W-1:0] LAST_BEAT  = ADDR_W'(BEATS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

    fc_feed_state_t    state_q, state_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [ADDR_W-1:0] beat_q, beat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic [FC_AW-1:0]  lane_q [FC_LANES];
    logic [FC_AW-1:0]  lane_d [FC_LANES];
    logic              mac_valid_q, mac_valid_d;
    logic              mac_start_q, mac_start_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              err_timeout_q, err_timeout_d;

    logic              accept;
    logic [FC_LANES-1:0] wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [FC_AW-1:0]  rd_data [FC_LANES];
    logic              emit;
    logic [ADDR_W-1:0] emit_beat;
    logic              bypass;

    assign feat_ready_o = ~rst_i & ((state_q == IDLE) | (state_q == FILL));
    assign accept       = feat_valid_i & feat_ready_o;

    always_comb begin
        wr_sel  = '0;
        wr_addr = '0;
        if (wr_idx_q < BANK1_BASE) begin
            wr_sel  = 3'b001;
            wr_addr = ADDR_W'(wr_idx_q);
        end else if (wr_idx_q < BANK2_BASE) begin
            wr_sel  = 3'b010;
            wr_addr = ADDR_W'(wr_idx_q - BANK1_BASE);
        end else begin
            wr_sel  = 3'b100;
            wr_addr = ADDR_W'(wr_idx_q - BANK2_BASE);
        end
    end

    // Beat k reads address BEATS-1-k from every bank, matching the MAC's weight order.
    assign rd_addr = LAST_BEAT - emit_beat;

    for (genvar g = 0; g < FC_LANES; g++) begin : g_bank
        fc_bank #(
            .DEPTH (BEATS),
            .W     (FC_AW),
            .AW    (ADDR_W)
        ) u_bank (
            .clk_i   (clk_i),
            .we_i    (accept & wr_sel[g]),
            .waddr_i (wr_addr),
            .wdata_i (feat_data_i),
            .raddr_i (rd_addr),
            .rdata_o (rd_data[g])
        );
    end

    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        beat_d        = beat_q;
        wait_d        = '0;
        emit          = 1'b0;
        emit_beat     = '0;
        bypass        = 1'b0;
        frame_done_d  = 1'b0;
        err_timeout_d = 1'b0;

        unique case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    if (wr_idx_q == LAST_IDX) begin
                        state_d  = STREAM;
                        wr_idx_d = '0;
                        beat_d   = '0;
                        emit     = 1'b1;
                        bypass   = 1'b1;
                    end else begin
                        state_d  = FILL;
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end
                end
            end
            STREAM: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = WAIT_DONE;
                    beat_d  = '0;
                end else begin
                    beat_d    = beat_q + ADDR_W'(1);
                    emit      = 1'b1;
                    emit_beat = beat_q + ADDR_W'(1);
                end
            end
            WAIT_DONE: begin
                if (mac_done_i) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    state_d       = IDLE;
                    err_timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Beat 0 is loaded on the same edge that writes the final word, whose bank location is
    // exactly the one beat 0 reads on lane 3, so that lane takes the incoming word directly.
    always_comb begin
        mac_valid_d = emit;
        mac_start_d = emit & (emit_beat == '0);
        for (int l = 0; l < FC_LANES; l++) begin
            lane_d[l] = emit ? rd_data[l] : '0;
        end
        if (bypass) begin
            lane_d[FC_LANES-1] = feat_data_i;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            wr_idx_q      <= '0;
            beat_q        <= '0;
            wait_q        <= '0;
            lane_q        <= '{default: '0};
            mac_valid_q   <= 1'b0;
            mac_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            beat_q        <= beat_d;
            wait_q        <= wait_d;
            lane_q        <= lane_d;
            mac_valid_q   <= mac_valid_d;
            mac_start_q   <= mac_start_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign mac_in1_o     = lane_q[0];
    assign mac_in2_o     = lane_q[1];
    assign mac_in3_o     = lane_q[2];
    assign mac_valid_o   = mac_valid_q;
    assign mac_start_o   = mac_start_q;
    assign busy_o        = busy_q;
    assign frame_done_o  = frame_done_q;
    assign err_timeout_o = err_timeout_q;

endmodule

// File: tb/tb_fc_feeder.sv
// Self-checking bench for fc_feeder: a frame-level behavioural model checked every cycle,
// plus hand-computed expectations for beat contents, stream length and timeout latency.
module tb_fc_feeder;

    localparam int TIMEOUT = 63;

    logic       clk;
    logic       rst;
    logic       feat_valid;
    logic       feat_ready;
    logic [1:0] feat_data;
    logic [1:0] mac_in1;
    logic [1:0] mac_in2;
    logic [1:0] mac_in3;
    logic       mac_valid;
    logic       mac_start;
    logic       mac_done;
    logic       busy;
    logic       frame_done;
    logic       err_timeout;

    int vectors     = 0;
    int miscompares = 0;

    fc_feeder #(
        .BEATS   (36),
        .N_LANE  (3),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .feat_valid_i  (feat_valid),
        .feat_ready_o  (feat_ready),
        .feat_data_i   (feat_data),
        .mac_in1_o     (mac_in1),
        .mac_in2_o     (mac_in2),
        .mac_in3_o     (mac_in3),
        .mac_valid_o   (mac_valid),
        .mac_start_o   (mac_start),
        .mac_done_i    (mac_done),
        .busy_o        (busy),
        .frame_done_o  (frame_done),
        .err_timeout_o (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level model: phase 0 collects words, phase 1 streams, phase 2 waits for the MAC.
    int         m_frame [108];
    int         m_n     = 0;
    int         m_phase = 0;
    int         m_beat  = 0;
    int         m_wait  = 0;
    bit         check_en = 1'b0;
    logic       e_valid, e_start, e_fd, e_err;
    logic [1:0] e_in1, e_in2, e_in3;

    task automatic modelEmit(input int k);
        e_valid = 1'b1;
        e_start = (k == 0);
        e_in1   = 2'(m_frame[35 - k]);
        e_in2   = 2'(m_frame[71 - k]);
        e_in3   = 2'(m_frame[107 - k]);
    endtask

    always @(posedge clk) begin
        e_valid = 1'b0;
        e_start = 1'b0;
        e_fd    = 1'b0;
        e_err   = 1'b0;
        e_in1   = 2'd0;
        e_in2   = 2'd0;
        e_in3   = 2'd0;
        if (rst) begin
            m_phase  = 0;
            m_n      = 0;
            check_en = 1'b1;
        end else begin
            case (m_phase)
                0: if (feat_valid) begin
                    m_frame[m_n] = int'(feat_data);
                    m_n++;
                    if (m_n == 108) begin
                        m_phase = 1;
                        m_beat  = 0;
                        modelEmit(0);
                    end
                end
                1: begin
                    m_beat++;
                    if (m_beat == 36) begin
                        m_phase = 2;
                        m_wait  = 0;
                    end else begin
                        modelEmit(m_beat);
                    end
                end
                default: begin
                    if (mac_done) begin
                        m_phase = 0;
                        m_n     = 0;
                        e_fd    = 1'b1;
                    end else begin
                        m_wait++;
                        if (m_wait == TIMEOUT) begin
                            m_phase = 0;
                            m_n     = 0;
                            e_err   = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("feat_ready", 32'(feat_ready), 32'(!rst && m_phase == 0));
            checkOutput("busy", 32'(busy), 32'(m_phase != 0 || m_n > 0));
            checkOutput("mac_valid", 32'(mac_valid), 32'(e_valid));
            checkOutput("mac_start", 32'(mac_start), 32'(e_start));
            checkOutput("mac_in1", 32'(mac_in1), 32'(e_in1));
            checkOutput("mac_in2", 32'(mac_in2), 32'(e_in2));
            checkOutput("mac_in3", 32'(mac_in3), 32'(e_in3));
            checkOutput("frame_done", 32'(frame_done), 32'(e_fd));
            checkOutput("err_timeout", 32'(err_timeout), 32'(e_err));
        end
    end

    function automatic logic [1:0] patt(input int p, input int i);
        case (p)
            0:       return 2'(i % 4);
            1:       return 2'((3 * i + 1) % 4);
            2:       return 2'((i >> 2) ^ i);
            default: return 2'((i + i / 5) % 4);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] d, input logic done);
        feat_valid = v;
        feat_data  = d;
        mac_done   = done;
    endtask

    // Leaves the bench in the cycle right after the final word is accepted.
    task automatic feedFrame(input int p, input bit gaps, input logic done);
        for (int i = 0; i < 108; i++) begin
            if (gaps && (i % 7 == 3)) begin
                applyStimulus(1'b0, 2'd0, done);
                step();
                step();
            end
            applyStimulus(1'b1, patt(p, i), done);
            step();
        end
    endtask

    logic [1:0] cap1 [36];
    logic [1:0] cap2 [36];
    logic [1:0] cap3 [36];
    logic [1:0] ref1 [36];
    logic [1:0] ref2 [36];
    logic [1:0] ref3 [36];

    // Samples 36 consecutive cycles starting now; ends in the cycle after the last beat.
    task automatic captureStream(output int nvalid, output int nstart, output int nready);
        nvalid = 0;
        nstart = 0;
        nready = 0;
        for (int k = 0; k < 36; k++) begin
            cap1[k] = mac_in1;
            cap2[k] = mac_in2;
            cap3[k] = mac_in3;
            if (mac_valid) nvalid++;
            if (mac_start) nstart++;
            if (feat_ready) nready++;
            step();
        end
    endtask

    function automatic int streamErrors(input int p);
        int errs = 0;
        for (int k = 0; k < 36; k++) begin
            if (cap1[k] !== patt(p, 35 - k)) errs++;
            if (cap2[k] !== patt(p, 71 - k)) errs++;
            if (cap3[k] !== patt(p, 107 - k)) errs++;
        end
        return errs;
    endfunction

    initial begin
        int nvalid, nstart, nready, n, diffs;
        rst = 1'b1;
        applyStimulus(1'b0, 2'd0, 1'b0);
        repeat (3) step();
        checkOutput("rst_feat_ready", 32'(feat_ready), 32'd0);
        checkOutput("rst_mac_valid", 32'(mac_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_rst", 32'(feat_ready), 32'd1);

        // Frame A: i mod 4, valid held high through the stream, MAC never answers.
        feedFrame(0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 1'b0);
        checkOutput("A_beat0_start", 32'(mac_start), 32'd1);
        captureStream(nvalid, nstart, nready);
        applyStimulus(1'b0, 2'd0, 1'b0);
        checkOutput("A_beat0_in1", 32'(cap1[0]), 32'd3);
        checkOutput("A_beat0_in2", 32'(cap2[0]), 32'd3);
        checkOutput("A_beat0_in3", 32'(cap3[0]), 32'd3);
        checkOutput("A_beat10_in2", 32'(cap2[10]), 32'd1);
        checkOutput("A_beat35_in1", 32'(cap1[35]), 32'd0);
        checkOutput("A_beat35_in2", 32'(cap2[35]), 32'd0);
        checkOutput("A_beat35_in3", 32'(cap3[35]), 32'd0);
        checkOutput("A_valid_count", 32'(nvalid), 32'd36);
        checkOutput("A_start_count", 32'(nstart), 32'd1);
        checkOutput("A_ready_in_stream", 32'(nready), 32'd0);
        checkOutput("A_valid_after_35", 32'(mac_valid), 32'd0);
        checkOutput("A_stream_content", 32'(streamErrors(0)), 32'd0);
        for (int k = 0; k < 36; k++) begin
            ref1[k] = cap1[k];
            ref2[k] = cap2[k];
            ref3[k] = cap3[k];
        end
        n = 0;
        do begin
            step();
            n++;
        end while (!err_timeout && n < 200);
        checkOutput("A_timeout_latency", 32'(n), 32'd63);
        checkOutput("A_timeout_ready", 32'(feat_ready), 32'd1);
        checkOutput("A_timeout_busy", 32'(busy), 32'd0);
        step();
        checkOutput("A_timeout_pulse_end", 32'(err_timeout), 32'd0);

        // Frame B: same data with valid gaps; a stale mac_done is held high throughout.
        feedFrame(0, 1'b1, 1'b1);
        applyStimulus(1'b0, 2'd0, 1'b1);
        checkOutput("B_stream_starts", 32'(mac_start), 32'd1);
        captureStream(nvalid, nstart, nready);
        diffs = 0;
        for (int k = 0; k < 36; k++) begin
            if (cap1[k] !== ref1[k] || cap2[k] !== ref2[k] || cap3[k] !== ref3[k]) diffs++;
        end
        checkOutput("B_same_as_A", 32'(diffs), 32'd0);
        checkOutput("B_valid_count", 32'(nvalid), 32'd36);
        checkOutput("B_wait_no_done_yet", 32'(frame_done), 32'd0);
        step();
        checkOutput("B_frame_done", 32'(frame_done), 32'd1);
        checkOutput("B_ready_after_done", 32'(feat_ready), 32'd1);
        step();
        checkOutput("B_frame_done_once", 32'(frame_done), 32'd0);

        // Frame C is aborted by reset at beat 10.
        feedFrame(1, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0);
        repeat (10) step();
        checkOutput("C_beat10_valid", 32'(mac_valid), 32'd1);
        rst = 1'b1;
        step();
        checkOutput("C_rst_valid", 32'(mac_valid), 32'd0);
        checkOutput("C_rst_lanes", 32'({mac_in1, mac_in2, mac_in3}), 32'd0);
        checkOutput("C_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Frame D streams cleanly, then frame E follows back-to-back after frame_done.
        feedFrame(2, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0);
        captureStream(nvalid, nstart, nready);
        checkOutput("D_beat0_in1", 32'(cap1[0]), 32'd3);
        checkOutput("D_beat0_in2", 32'(cap2[0]), 32'd2);
        checkOutput("D_beat0_in3", 32'(cap3[0]), 32'd1);
        checkOutput("D_stream_content", 32'(streamErrors(2)), 32'd0);
        checkOutput("D_ready_in_stream", 32'(nready), 32'd0);
        step();
        step();
        checkOutput("D_ready_in_wait", 32'(feat_ready), 32'd0);
        applyStimulus(1'b0, 2'd0, 1'b1);
        step();
        checkOutput("D_frame_done", 32'(frame_done), 32'd1);
        checkOutput("D_ready_after_done", 32'(feat_ready), 32'd1);
        feedFrame(3, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0);
        captureStream(nvalid, nstart, nready);
        checkOutput("E_beat0_in1", 32'(cap1[0]), 32'd2);
        checkOutput("E_beat0_in2", 32'(cap2[0]), 32'd1);
        checkOutput("E_beat0_in3", 32'(cap3[0]), 32'd0);
        checkOutput("E_stream_content", 32'(streamErrors(3)), 32'd0);
        checkOutput("E_valid_count", 32'(nvalid), 32'd36);
        applyStimulus(1'b0, 2'd0, 1'b1);
        step();
        checkOutput("E_frame_done", 32'(frame_done), 32'd1);
        applyStimulus(1'b0, 2'd0, 1'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
